segment_regs: RTL and testbench
===============================

// Module: segment_regs
// PURPOSE
//  Bus-mapped control register block for the two on-board 7-segment digits; drives segment_ext directly.
//  Sits on the PicoRV32 iomem bus and holds the digit/decimal-point values and per-digit enables.
//  Adds a per-digit blink timer and an optional binary-to-BCD converter for 0..99 values.
//  All outputs are registered, so the decoder downstream sees glitch-free data.
// PARAMETERS
//  BLINK_DIV_W        24            width of blink divider counter/register
//  BLINK_DIV_DEFAULT  24'd6000000   reset reload value; half blink period in clk cycles (0.5 s @ 12 MHz)
// PORTS
//  clk           in   1   system clock
//  resetn        in   1   asynchronous active-low reset
//  iomem_sel     in   1   address decode hit for this block (from SoC decoder)
//  iomem_valid   in   1   bus request valid
//  iomem_ready   out  1   one-cycle acknowledge
//  iomem_wstrb   in   4   byte write strobes; 4'b0000 = read
//  iomem_addr    in   32  byte address; only [3:2] decoded
//  iomem_wdata   in   32  write data
//  iomem_rdata   out  32  read data, valid while iomem_ready=1, else 0
//  disable1      out  1   1 = blank digit 1
//  disable2      out  1   1 = blank digit 2
//  seg_data_1    out  5   {dp, hex nibble} for digit 1
//  seg_data_2    out  5   {dp, hex nibble} for digit 2
// BEHAVIOUR
//  Register map (addr[3:2]):
//   0 DATA  [3:0] dig1, [4] dp1, [11:8] dig2, [12] dp2; other bits RO 0; reset 0
//   1 CTRL  [0] en1, [1] en2, [2] blink1, [3] blink2; reset 0
//   2 DIV   [BLINK_DIV_W-1:0] blink reload; reset BLINK_DIV_DEFAULT
//   3 BCD   write [6:0] = binary value; read [0] busy, [1] ovf (SEG_BCD_EN only)
//  Bus: transfer accepted when iomem_valid & iomem_sel & !iomem_ready; iomem_ready=1 exactly the
//   next cycle, then 0 for at least one cycle (one access per 2 clocks). Writes honour wstrb per byte
//   and take effect on the accept edge. Unselected cycles: ready=0, rdata=0.
//  Blink: counter loads DIV and decrements every clk; at 0 reloads DIV and toggles phase (reset phase=0).
//   Any DIV write reloads the counter and clears phase. DIV=0 -> phase toggles every cycle.
//  Outputs (registered, 1 clk after register change):
//   disableN = !enN | (blinkN & phase); seg_data_N = {dpN, digN}.
//  Reset values: iomem_ready=0, iomem_rdata=0, disable1=disable2=1, seg_data_1=seg_data_2=0.
//  Reset mid-operation (async): all state, including any BCD conversion in progress, returns to reset values immediately.
// CONFIGURATION
//  Macro SEG_BCD_EN defined: BCD write with value<=99 starts a shift-add-3 FSM
//   IDLE->SHIFT (7 cycles, 1 bit/cycle)->COMMIT->IDLE; COMMIT writes tens to dig2, units to dig1;
//   dp bits are untouched; ovf cleared. Result is in DATA 8 clks after accept; busy=1 throughout.
//   Value>99: no conversion, dig1=dig2=4'hE written in 1 clk, ovf=1.
//   BCD write while busy restarts the conversion with the new value.
//   A DATA write during a conversion lands normally; COMMIT then overwrites only the digit fields.
//  Macro undefined: BCD address reads 0, writes ignored; no FSM logic is synthesised.
// STRUCTURE
//  Package seg_pkg: register offsets (SEG_REG_DATA/CTRL/DIV/BCD), DATA/CTRL field bit positions,
//   BCD FSM state encoding (IDLE, SHIFT, COMMIT).
//  Sub-module seg_bin2bcd (under SEG_BCD_EN): start/value in, busy/done/tens/units out.
//  Top holds bus FSM, registers, blink counter and output registers.
// TESTING
//  1 Reset, no writes -> disable1=disable2=1, seg_data_*=0; ready never asserts with sel=0.
//  2 Write DATA=32'h0000_1A05, CTRL=4'h3 -> seg_data_1=5'h05, seg_data_2=5'h1A, disables 0;
//    readback of DATA=32'h1A05; ready pulses exactly 1 clk after each accept.
//  3 DIV=3, CTRL=4'hF -> both disables toggle every 4 clks; DIV write mid-period clears phase (visible).
//  4 wstrb=4'b0010 write 32'hFFFF_FFFF to DATA -> only dig2/dp2 change to 4'hF/1; dig1 kept.
//  5 (SEG_BCD_EN) BCD write 57 -> busy=1 for 8 clks, then dig2=5, dig1=7, dp bits kept;
//    write 120 -> dig1=dig2=E, ovf=1; BCD write while busy -> only the second value appears.
//  6 resetn asserted mid-conversion -> outputs at reset values immediately, busy=0 after release.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the 7-segment register block.
//  Register offsets (iomem_addr[3:2]), DATA/CTRL/BCD field positions,
//  digit payload struct, BCD FSM state encoding and a byte-merge helper.
package seg_pkg;

   localparam int unsigned BUS_W     = 32;
   localparam int unsigned DIG_W     = 4;
   localparam int unsigned BCD_BIN_W = 7;
   localparam int unsigned BCD_MAX   = 99;

   localparam logic [1:0] SEG_REG_DATA = 2'd0;
   localparam logic [1:0] SEG_REG_CTRL = 2'd1;
   localparam logic [1:0] SEG_REG_DIV  = 2'd2;
   localparam logic [1:0] SEG_REG_BCD  = 2'd3;

   localparam int unsigned DATA_DIG1_LSB = 0;
   localparam int unsigned DATA_DP1_BIT  = 4;
   localparam int unsigned DATA_DIG2_LSB = 8;
   localparam int unsigned DATA_DP2_BIT  = 12;

   localparam int unsigned CTRL_EN1_BIT    = 0;
   localparam int unsigned CTRL_EN2_BIT    = 1;
   localparam int unsigned CTRL_BLINK1_BIT = 2;
   localparam int unsigned CTRL_BLINK2_BIT = 3;

   localparam int unsigned BCD_BUSY_BIT = 0;
   localparam int unsigned BCD_OVF_BIT  = 1;

   typedef enum logic [1:0] {
      BCD_IDLE   = 2'd0,
      BCD_SHIFT  = 2'd1,
      BCD_COMMIT = 2'd2
   } bcd_state_t;

   // One digit as seen by the downstream decoder: {dp, hex nibble}.
   typedef struct packed {
      logic             dp;
      logic [DIG_W-1:0] dig;
   } seg_digit_t;

   // Replace the bytes of old_v selected by strb with the matching bytes of new_v.
   function automatic logic [BUS_W-1:0] merge_bytes(input logic [BUS_W-1:0] old_v,
                                                    input logic [BUS_W-1:0] new_v,
                                                    input logic [3:0]       strb);
      logic [BUS_W-1:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// seg_bin2bcd: serial shift-add-3 converter for binary values 0..99.
//  Only built when SEG_BCD_EN is defined.
//  Ports: clk, resetn (async active-low); start/value in (start restarts any
//  conversion in flight); busy (conversion in progress), done (COMMIT cycle,
//  tens/units valid), tens/units out.
`ifdef SEG_BCD_EN
module seg_bin2bcd
   import seg_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [BCD_BIN_W-1:0] value,
   output logic                 busy,
   output logic                 done,
   output logic [DIG_W-1:0]     tens,
   output logic [DIG_W-1:0]     units
);

   localparam int unsigned SHIFT_W = BCD_BIN_W + 2*DIG_W;
   localparam int unsigned CNT_W   = 3;

   bcd_state_t           state_q, state_d;
   logic [SHIFT_W-1:0]   shift_q;
   logic [CNT_W-1:0]     cnt_q;

   // One double-dabble step: adjust each BCD nibble >= 5 by +3, then shift left.
   function automatic logic [SHIFT_W-1:0] dabble(input logic [SHIFT_W-1:0] v);
      logic [SHIFT_W-1:0] r;
      r = v;
      if (r[BCD_BIN_W +: DIG_W] >= 4'd5)
         r[BCD_BIN_W +: DIG_W] = r[BCD_BIN_W +: DIG_W] + 4'd3;
      if (r[BCD_BIN_W+DIG_W +: DIG_W] >= 4'd5)
         r[BCD_BIN_W+DIG_W +: DIG_W] = r[BCD_BIN_W+DIG_W +: DIG_W] + 4'd3;
      return {r[SHIFT_W-2:0], 1'b0};
   endfunction

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= BCD_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; a start in any state (re)enters SHIFT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BCD_IDLE:   if (start) state_d = BCD_SHIFT;
         BCD_SHIFT:  if (start) state_d = BCD_SHIFT;
                     else if (cnt_q == CNT_W'(BCD_BIN_W-1)) state_d = BCD_COMMIT;
         BCD_COMMIT: state_d = start ? BCD_SHIFT : BCD_IDLE;
         default:    state_d = BCD_IDLE;
      endcase
   end

   // Status decode; a restart during COMMIT suppresses the stale result.
   always_comb begin
      busy = (state_q != BCD_IDLE);
      done = (state_q == BCD_COMMIT) && !start;
   end

   // Shift register and bit counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (start) begin
         shift_q <= SHIFT_W'(value);
         cnt_q   <= '0;
      end else if (state_q == BCD_SHIFT) begin
         shift_q <= dabble(shift_q);
         cnt_q   <= cnt_q + CNT_W'(1);
      end
   end

   assign units = shift_q[BCD_BIN_W +: DIG_W];
   assign tens  = shift_q[BCD_BIN_W+DIG_W +: DIG_W];

endmodule
`endif

// File: rtl/segment_regs.sv
// segment_regs: iomem-mapped control registers for two 7-segment digits.
//  Holds DATA/CTRL/DIV (and BCD when SEG_BCD_EN is defined), a shared blink
//  timer and registered digit outputs.
//  Ports: clk, resetn (async active-low); iomem_sel/valid/wstrb/addr/wdata in,
//  iomem_ready/rdata out (one-cycle acknowledge, rdata 0 outside ready);
//  disable1/disable2 (1 = blank), seg_data_1/seg_data_2 ({dp, nibble}).
//  Optional feature macro: SEG_BCD_EN (binary-to-BCD converter at offset 3).
module segment_regs
   import seg_pkg::*;
#(
   parameter int unsigned               BLINK_DIV_W       = 24,
   parameter logic [BLINK_DIV_W-1:0]    BLINK_DIV_DEFAULT = BLINK_DIV_W'(6000000)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             iomem_sel,
   input  logic             iomem_valid,
   output logic             iomem_ready,
   input  logic [3:0]       iomem_wstrb,
   input  logic [BUS_W-1:0] iomem_addr,
   input  logic [BUS_W-1:0] iomem_wdata,
   output logic [BUS_W-1:0] iomem_rdata,
   output logic             disable1,
   output logic             disable2,
   output logic [4:0]       seg_data_1,
   output logic [4:0]       seg_data_2
);

   logic [1:0]             reg_sel;
   logic                   accept, wr, rd;
   logic                   wr_data, wr_ctrl, wr_div;
   logic [BUS_W-1:0]       rdata_c;
   logic [BUS_W-1:0]       div_merged;
   logic [BLINK_DIV_W-1:0] div_new;

   seg_digit_t             dig1_q, dig2_q;
   logic                   en1_q, en2_q, blink1_q, blink2_q;
   logic [BLINK_DIV_W-1:0] div_q, cnt_q;
   logic                   phase_q;

   logic                   unused_bits;

   // Bus decode; the !ready term spaces accesses two clocks apart.
   assign reg_sel = iomem_addr[3:2];
   assign accept  = iomem_valid & iomem_sel & ~iomem_ready;
   assign wr      = accept & (|iomem_wstrb);
   assign rd      = accept & ~(|iomem_wstrb);
   assign wr_data = wr & (reg_sel == SEG_REG_DATA);
   assign wr_ctrl = wr & (reg_sel == SEG_REG_CTRL);
   assign wr_div  = wr & (reg_sel == SEG_REG_DIV);

   assign div_merged  = merge_bytes(BUS_W'(div_q), iomem_wdata, iomem_wstrb);
   assign div_new     = div_merged[BLINK_DIV_W-1:0];
   assign unused_bits = &{1'b0, iomem_addr[BUS_W-1:4], iomem_addr[1:0], div_merged};

`ifdef SEG_BCD_EN
   logic             bcd_wr, bcd_start, bcd_ovf_set;
   logic             bcd_busy, bcd_done, bcd_ovf_q;
   logic [DIG_W-1:0] bcd_tens, bcd_units;

   assign bcd_wr      = wr & (reg_sel == SEG_REG_BCD) & iomem_wstrb[0];
   assign bcd_start   = bcd_wr & (iomem_wdata[BCD_BIN_W-1:0] <= BCD_BIN_W'(BCD_MAX));
   assign bcd_ovf_set = bcd_wr & ~(iomem_wdata[BCD_BIN_W-1:0] <= BCD_BIN_W'(BCD_MAX));

   seg_bin2bcd u_bin2bcd (
      .clk    (clk),
      .resetn (resetn),
      .start  (bcd_start),
      .value  (iomem_wdata[BCD_BIN_W-1:0]),
      .busy   (bcd_busy),
      .done   (bcd_done),
      .tens   (bcd_tens),
      .units  (bcd_units)
   );

   // Overflow flag: set by an out-of-range write, cleared by a completed conversion.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)          bcd_ovf_q <= 1'b0;
      else if (bcd_ovf_set) bcd_ovf_q <= 1'b1;
      else if (bcd_done)    bcd_ovf_q <= 1'b0;
   end
`endif

   // Read mux.
   always_comb begin
      rdata_c = '0;
      case (reg_sel)
         SEG_REG_DATA: begin
            rdata_c[DATA_DIG1_LSB +: DIG_W] = dig1_q.dig;
            rdata_c[DATA_DP1_BIT]           = dig1_q.dp;
            rdata_c[DATA_DIG2_LSB +: DIG_W] = dig2_q.dig;
            rdata_c[DATA_DP2_BIT]           = dig2_q.dp;
         end
         SEG_REG_CTRL: begin
            rdata_c[CTRL_EN1_BIT]    = en1_q;
            rdata_c[CTRL_EN2_BIT]    = en2_q;
            rdata_c[CTRL_BLINK1_BIT] = blink1_q;
            rdata_c[CTRL_BLINK2_BIT] = blink2_q;
         end
         SEG_REG_DIV: rdata_c = BUS_W'(div_q);
         SEG_REG_BCD: begin
`ifdef SEG_BCD_EN
            rdata_c[BCD_BUSY_BIT] = bcd_busy;
            rdata_c[BCD_OVF_BIT]  = bcd_ovf_q;
`endif
         end
         default: ;
      endcase
   end

   // Bus response: ready one cycle after accept, rdata only for reads.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
      end else begin
         iomem_ready <= accept;
         iomem_rdata <= rd ? rdata_c : '0;
      end
   end

   // DATA register; converter results land after bus writes so they win digit fields.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dig1_q <= '0;
         dig2_q <= '0;
      end else begin
         if (wr_data && iomem_wstrb[0]) begin
            dig1_q.dig <= iomem_wdata[DATA_DIG1_LSB +: DIG_W];
            dig1_q.dp  <= iomem_wdata[DATA_DP1_BIT];
         end
         if (wr_data && iomem_wstrb[1]) begin
            dig2_q.dig <= iomem_wdata[DATA_DIG2_LSB +: DIG_W];
            dig2_q.dp  <= iomem_wdata[DATA_DP2_BIT];
         end
`ifdef SEG_BCD_EN
         if (bcd_done) begin
            dig1_q.dig <= bcd_units;
            dig2_q.dig <= bcd_tens;
         end
         if (bcd_ovf_set) begin
            dig1_q.dig <= 4'hE;
            dig2_q.dig <= 4'hE;
         end
`endif
      end
   end

   // CTRL register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         en1_q    <= 1'b0;
         en2_q    <= 1'b0;
         blink1_q <= 1'b0;
         blink2_q <= 1'b0;
      end else if (wr_ctrl && iomem_wstrb[0]) begin
         en1_q    <= iomem_wdata[CTRL_EN1_BIT];
         en2_q    <= iomem_wdata[CTRL_EN2_BIT];
         blink1_q <= iomem_wdata[CTRL_BLINK1_BIT];
         blink2_q <= iomem_wdata[CTRL_BLINK2_BIT];
      end
   end

   // DIV register and blink timer; a DIV write restarts the period with phase cleared.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q   <= BLINK_DIV_DEFAULT;
         cnt_q   <= BLINK_DIV_DEFAULT;
         phase_q <= 1'b0;
      end else if (wr_div) begin
         div_q   <= div_new;
         cnt_q   <= div_new;
         phase_q <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q   <= div_q;
         phase_q <= ~phase_q;
      end else begin
         cnt_q   <= cnt_q - BLINK_DIV_W'(1);
      end
   end

   // Registered digit outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         disable1   <= 1'b1;
         disable2   <= 1'b1;
         seg_data_1 <= '0;
         seg_data_2 <= '0;
      end else begin
         disable1   <= ~en1_q | (blink1_q & phase_q);
         disable2   <= ~en2_q | (blink2_q & phase_q);
         seg_data_1 <= dig1_q;
         seg_data_2 <= dig2_q;
      end
   end

endmodule

// File: tb/tb_segment_regs.sv
// tb_segment_regs: directed bench for segment_regs. Bus accesses push their
// expected response into a scoreboard; a negedge monitor pops and compares on
// every ready pulse and checks ready/rdata stay 0 otherwise.
module tb_segment_regs;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_sel = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'h0;
   logic [31:0] iomem_addr = 32'h0;
   logic [31:0] iomem_wdata = 32'h0;
   logic [31:0] iomem_rdata;
   logic        disable1, disable2;
   logic [4:0]  seg_data_1, seg_data_2;

   localparam logic [1:0] R_DATA = 2'd0;
   localparam logic [1:0] R_CTRL = 2'd1;
   localparam logic [1:0] R_DIV  = 2'd2;
   localparam logic [1:0] R_BCD  = 2'd3;

   int n_pass = 0;
   int n_total = 0;
   int n_iss = 0;
   int n_seen = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   segment_regs dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_sel   (iomem_sel),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .disable1    (disable1),
      .disable2    (disable2),
      .seg_data_1  (seg_data_1),
      .seg_data_2  (seg_data_2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic chk_out(input string name, input logic d1, input logic d2,
                          input logic [4:0] s1, input logic [4:0] s2);
      chk({name, "_dis1"}, 32'(disable1), 32'(d1));
      chk({name, "_dis2"}, 32'(disable2), 32'(d2));
      chk({name, "_seg1"}, 32'(seg_data_1), 32'(s1));
      chk({name, "_seg2"}, 32'(seg_data_2), 32'(s2));
   endtask

   // Monitor: every ready pulse must match the oldest outstanding access.
   always @(negedge clk) begin : mon
      string       nm;
      logic [31:0] ex;
      if (n_seen != n_iss) begin
         n_seen++;
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_empty: got response required none outstanding");
         end else begin
            nm = name_q.pop_front();
            ex = exp_q.pop_front();
            chk({nm, "_ready"}, 32'(iomem_ready), 32'd1);
            chk({nm, "_rdata"}, iomem_rdata, ex);
         end
      end else begin
         chk("idle_ready", 32'(iomem_ready), 32'd0);
         chk("idle_rdata", iomem_rdata, 32'd0);
      end
   end

   // One access: drive after a negedge, accept on the next posedge, release.
   task automatic bus(input logic [1:0] r, input logic [3:0] strb, input logic [31:0] data,
                      input logic [31:0] exp, input string name);
      @(negedge clk);
      iomem_sel   = 1'b1;
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0300_0000 | {28'h0, r, 2'b00};
      iomem_wstrb = strb;
      iomem_wdata = data;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      n_iss++;
      @(negedge clk);
      iomem_sel   = 1'b0;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      iomem_wdata = 32'h0;
   endtask

   task automatic wr(input logic [1:0] r, input logic [3:0] strb, input logic [31:0] data,
                     input string name);
      bus(r, strb, data, 32'h0, name);
   endtask

   task automatic rd(input logic [1:0] r, input logic [31:0] exp, input string name);
      bus(r, 4'h0, 32'h0, exp, name);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #1 chk_out("in_rst", 1'b1, 1'b1, 5'h00, 5'h00);
      @(negedge clk);
      resetn = 1'b1;

      // valid without sel must never be acknowledged
      iomem_valid = 1'b1;
      iomem_wstrb = 4'hF;
      iomem_wdata = 32'hFFFF_FFFF;
      repeat (4) @(negedge clk);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      iomem_wdata = 32'h0;
      chk_out("post_rst", 1'b1, 1'b1, 5'h00, 5'h00);
      rd(R_DATA, 32'h0, "rst_data");
      rd(R_CTRL, 32'h0, "rst_ctrl");
      rd(R_DIV, 32'h005B_8D80, "rst_div");
      rd(R_BCD, 32'h0, "rst_bcd");

      // Basic DATA/CTRL write and readback
      wr(R_DATA, 4'hF, 32'h0000_1A05, "w_data");
      wr(R_CTRL, 4'hF, 32'h0000_0003, "w_ctrl");
      @(negedge clk);
      chk_out("t2", 1'b0, 1'b0, 5'h05, 5'h1A);
      rd(R_DATA, 32'h0000_1A05, "rb_data");
      rd(R_CTRL, 32'h0000_0003, "rb_ctrl");

      // valid held high: accepts only every other clock
      @(negedge clk);
      iomem_sel   = 1'b1;
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0000_0000;
      iomem_wstrb = 4'h0;
      exp_q.push_back(32'h0000_1A05); name_q.push_back("held_a");
      exp_q.push_back(32'h0000_1A05); name_q.push_back("held_b");
      @(posedge clk); n_iss++;
      @(posedge clk);
      @(posedge clk); n_iss++;
      @(negedge clk);
      iomem_sel   = 1'b0;
      iomem_valid = 1'b0;

      // Blink: DIV=3 gives a 4-clock half period
      wr(R_DIV, 4'hF, 32'h0000_0003, "w_div");
      wr(R_CTRL, 4'hF, 32'h0000_000F, "w_ctrl_blink");
      for (int i = 3; i <= 13; i++) begin
         logic e;
         @(negedge clk);
         e = (i < 5) ? 1'b0 : (((i - 5) / 4) % 2 == 0);
         chk($sformatf("blink_%0d_d1", i), 32'(disable1), 32'(e));
         chk($sformatf("blink_%0d_d2", i), 32'(disable2), 32'(e));
      end
      // DIV rewrite while blanked clears phase immediately
      wr(R_DIV, 4'hF, 32'h0000_0003, "w_div_mid");
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         chk($sformatf("divclr_%0d", j), 32'(disable1), 32'(j == 5));
      end
      wr(R_CTRL, 4'hF, 32'h0000_0003, "w_ctrl_steady");

      // Byte strobes
      wr(R_DATA, 4'b0010, 32'hFFFF_FFFF, "w_strb1");
      @(negedge clk);
      chk_out("t4", 1'b0, 1'b0, 5'h05, 5'h1F);
      rd(R_DATA, 32'h0000_1F05, "rb_strb1");
      wr(R_DATA, 4'b0001, 32'h0000_0010, "w_strb0");
      rd(R_DATA, 32'h0000_1F10, "rb_strb0");

`ifdef SEG_BCD_EN
      // 57 -> tens 5, units 7, dps kept, result 8 clocks after accept
      wr(R_BCD, 4'hF, 32'd57, "w_bcd57");
      rd(R_BCD, 32'h1, "bcd_busy");
      repeat (6) @(negedge clk);
      chk_out("bcd57_early", 1'b0, 1'b0, 5'h10, 5'h1F);
      @(negedge clk);
      chk_out("bcd57", 1'b0, 1'b0, 5'h17, 5'h15);
      rd(R_DATA, 32'h0000_1517, "rb_bcd57");

      // restart: only the second value lands
      wr(R_BCD, 4'hF, 32'd12, "w_bcd12");
      wr(R_BCD, 4'hF, 32'd34, "w_bcd34");
      repeat (7) @(negedge clk);
      chk_out("restart_early", 1'b0, 1'b0, 5'h17, 5'h15);
      repeat (2) @(negedge clk);
      chk_out("restart", 1'b0, 1'b0, 5'h14, 5'h13);

      // overflow
      wr(R_BCD, 4'hF, 32'd120, "w_bcd120");
      @(negedge clk);
      chk_out("ovf", 1'b0, 1'b0, 5'h1E, 5'h1E);
      rd(R_BCD, 32'h2, "rb_ovf");
      rd(R_DATA, 32'h0000_1E1E, "rb_ovf_data");

      wr(R_BCD, 4'hF, 32'd57, "w_bcd_pre_rst");
`else
      // Converter absent: BCD writes are ignored, reads return 0
      wr(R_BCD, 4'hF, 32'd57, "w_bcd_off");
      rd(R_BCD, 32'h0, "rb_bcd_off");
      repeat (8) @(negedge clk);
      chk_out("bcd_off", 1'b0, 1'b0, 5'h10, 5'h1F);
      rd(R_DATA, 32'h0000_1F10, "rb_bcd_off_data");
`endif

      // Asynchronous reset mid-operation
      repeat (2) @(negedge clk);
      #2 resetn = 1'b0;
      #1 chk_out("async_rst", 1'b1, 1'b1, 5'h00, 5'h00);
      chk("async_rst_ready", 32'(iomem_ready), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      rd(R_BCD, 32'h0, "post_rst_bcd");
      rd(R_DATA, 32'h0, "post_rst_data");
      rd(R_CTRL, 32'h0, "post_rst_ctrl");
      rd(R_DIV, 32'h005B_8D80, "post_rst_div");
      repeat (10) @(negedge clk);
      chk_out("post_rst_final", 1'b1, 1'b1, 5'h00, 5'h00);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
